// File: rtl/maxima_serializer.sv
// Parallel-to-serial stage: captures a frame of packed spectral maxima on a load strobe
// and emits one frequency bin per cycle as FIFO writes, honouring fifo_full backpressure.
module maxima_serializer #(
  parameter int N_MAXIMA  = 16,
  parameter int WORD_W    = 25,
  parameter int FREQ_W    = 9,
  parameter int SKIP_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] maximas [N_MAXIMA],
  input  logic              fifo_full,
  output logic [FREQ_W-1:0] freq_out,
  output logic              freq_valid,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        dropped_count
);

  localparam int IDX_W = (N_MAXIMA > 1) ? $clog2(N_MAXIMA) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MAXIMA - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  logic              state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shadow_q [N_MAXIMA];
  logic [WORD_W-1:0] shadow_d [N_MAXIMA];
  logic              frame_done_q, frame_done_d;
  logic [7:0]        dropped_q, dropped_d;

  logic [WORD_W-1:0] cur;
  logic              empty;
  logic              in_shift;
  logic              retire;

  always_comb begin
    cur          = shadow_q[idx_q];
    empty        = (SKIP_ZERO != 0) && (cur[WORD_W-1:FREQ_W] == '0);
    in_shift     = (state_q == ST_SHIFT);
    // Empty slots retire even under backpressure since they never write the FIFO.
    retire       = in_shift && (empty || !fifo_full);
    freq_valid   = in_shift && !fifo_full && !empty;

    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    dropped_d    = dropped_q;

    if (!in_shift) begin
      if (load) begin
        shadow_d = maximas;
        idx_d    = '0;
        state_d  = ST_SHIFT;
      end
    end else begin
      if (load && (dropped_q != 8'hFF)) begin
        dropped_d = dropped_q + 8'd1;
      end
      // idx is left on the last entry at frame end so freq_out holds its value in IDLE.
      if (retire) begin
        if (idx_q == LAST_IDX) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
      dropped_q    <= '0;
      for (int unsigned i = 0; i < N_MAXIMA; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
      dropped_q    <= dropped_d;
      shadow_q     <= shadow_d;
    end
  end

  assign freq_out      = cur[FREQ_W-1:0];
  assign busy          = in_shift;
  assign frame_done    = frame_done_q;
  assign dropped_count = dropped_q;

endmodule

// File: tb/tb_maxima_serializer.sv
// Scoreboard bench for maxima_serializer: directed frames push expected writes and
// frame_done cycles into queues; a negedge monitor pops and compares them.
module tb_maxima_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [24:0] maximas [16];
  logic        fifo_full;
  logic [8:0]  freq_out;
  logic        freq_valid;
  logic        busy;
  logic        frame_done;
  logic [7:0]  dropped_count;

  maxima_serializer #(
    .N_MAXIMA (16),
    .WORD_W   (25),
    .FREQ_W   (9),
    .SKIP_ZERO(1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .maximas      (maximas),
    .fifo_full    (fifo_full),
    .freq_out     (freq_out),
    .freq_valid   (freq_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .dropped_count(dropped_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int freq;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (fifo_full) check("no_write_when_full", int'(freq_valid), 0);
    if (freq_valid) begin
      if (wq.size() == 0) begin
        check("unexpected_write", int'(freq_out), -1);
      end else begin
        e = wq.pop_front();
        check("write_freq", int'(freq_out), e.freq);
        check("write_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) begin
      check("done_not_busy", int'(busy), 0);
      if (dq.size() == 0) check("unexpected_frame_done", cyc, -1);
      else check("frame_done_cycle", cyc, dq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic set_frame(input int base, input logic [15:0] zmask);
    for (int i = 0; i < 16; i++) begin
      maximas[i] = {(zmask[i] ? 16'd0 : 16'(i + 1)), 9'(base + i)};
    end
  endtask

  // Entries from..to of a frame with bins base+i, written on consecutive cycles from start.
  task automatic push_run(input int base, input int from, input int to, input int start);
    wr_t e;
    for (int i = from; i <= to; i++) begin
      e.freq = base + i;
      e.cyc  = start + (i - from);
      wq.push_back(e);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_freq_out"}, int'(freq_out), 0);
    check({tag, "_freq_valid"}, int'(freq_valid), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_dropped"}, int'(dropped_count), 0);
  endtask

  initial begin
    int c;
    reset     = 1'b1;
    load      = 1'b0;
    fifo_full = 1'b0;
    set_frame(0, 16'h0000);
    #2;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Basic frame
    set_frame(100, 16'h0000);
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 15, c + 1);
    dq.push_back(c + 17);
    tick();
    load = 1'b0;
    check("busy_after_load", int'(busy), 1);
    wait_until(c + 19);

    // Backpressure on entry 5 for 3 cycles
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 4, c + 1);
    push_run(100, 5, 15, c + 9);
    dq.push_back(c + 20);
    tick();
    load = 1'b0;
    wait_until(c + 6);
    fifo_full = 1'b1;
    wait_until(c + 9);
    fifo_full = 1'b0;
    wait_until(c + 22);

    // Zero-magnitude skipping at entries 0, 7, 15
    set_frame(100, 16'b1000_0000_1000_0001);
    c = cyc;
    load = 1'b1;
    push_run(100, 1, 6, c + 2);
    push_run(100, 8, 14, c + 9);
    dq.push_back(c + 17);
    tick();
    load = 1'b0;
    wait_until(c + 19);

    // Drop counter: one load at cycle 5, then 300 more during a long stall
    set_frame(100, 16'h0000);
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 4, c + 1);
    push_run(100, 5, 15, c + 306);
    dq.push_back(c + 317);
    tick();
    load = 1'b0;
    wait_until(c + 5);
    set_frame(400, 16'h0000);
    load = 1'b1;
    tick();
    load = 1'b0;
    check("drop_first", int'(dropped_count), 1);
    load      = 1'b1;
    fifo_full = 1'b1;
    wait_until(c + 100);
    check("drop_mid", int'(dropped_count), 95);
    set_frame(450, 16'h0000);
    wait_until(c + 306);
    load      = 1'b0;
    fifo_full = 1'b0;
    check("drop_saturated", int'(dropped_count), 255);
    wait_until(c + 319);

    // Back-to-back: load coincident with frame_done
    set_frame(100, 16'h0000);
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 15, c + 1);
    dq.push_back(c + 17);
    tick();
    load = 1'b0;
    wait_until(c + 17);
    check("b2b_done_now", int'(frame_done), 1);
    set_frame(200, 16'h0000);
    load = 1'b1;
    push_run(200, 0, 15, c + 18);
    dq.push_back(c + 34);
    tick();
    load = 1'b0;
    wait_until(c + 36);

    // Reset mid-frame at entry 8
    set_frame(100, 16'h0000);
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 7, c + 1);
    tick();
    load = 1'b0;
    wait_until(c + 9);
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    wait_until(c + 12);
    reset = 1'b0;
    tick();
    c = cyc;
    load = 1'b1;
    push_run(100, 0, 15, c + 1);
    dq.push_back(c + 17);
    tick();
    load = 1'b0;
    wait_until(c + 20);

    check("writes_outstanding", wq.size(), 0);
    check("done_outstanding", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
